// File: rtl/stage5_commit_unit.sv
// Stage-5 commit: writeback formatting, register file, fetch PC, redirect and squash FSM.
// Optional write-through read bypass is enabled by defining STAGE5_BYPASS_EN.
module stage5_commit_unit #(
  parameter int XLEN         = 32,
  parameter int NREGS        = 32,
  parameter int FLUSH_CYCLES = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'('h100)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     valid_in,
  input  logic                     stall,
  input  logic                     is_load,
  input  logic                     is_store,
  input  logic                     is_branch,
  input  logic                     is_jal,
  input  logic                     is_jalr,
  input  logic [3:0]               branch_type,
  input  logic [3:0]               compare,
  input  logic [$clog2(NREGS)-1:0] rs1,
  input  logic [$clog2(NREGS)-1:0] rs2,
  input  logic [$clog2(NREGS)-1:0] rd,
  input  logic [XLEN-1:0]          instr_pc,
  input  logic [XLEN-1:0]          alu_output,
  input  logic [XLEN-1:0]          memory_read_value,
  input  logic [XLEN-1:0]          imm,
  input  logic [2:0]               load_type,
  output logic [XLEN-1:0]          instruction_addr,
  output logic [XLEN-1:0]          rs1_read,
  output logic [XLEN-1:0]          rs2_read,
  output logic                     redirect,
  output logic                     flush,
  output logic                     misaligned_trap,
  output logic [63:0]              retired_count
);

  // state  | meaning
  // IDLE   | slots commit normally
  // SQUASH | younger slots flushed; counter holds remaining squash cycles

  localparam int  AW   = $clog2(NREGS);
  localparam int  CW   = $clog2(FLUSH_CYCLES + 1);
  localparam bit  IS64 = (XLEN == 64);

  typedef enum logic [0:0] {IDLE, SQUASH} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            flush_nx;

  logic            commit;
  logic            take;
  logic            reg_we;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] next_target;
  logic [XLEN-1:0] rd_value;
  logic [XLEN-1:0] load_value;
  logic [XLEN-1:0] regs [NREGS];

  logic [63:0]     mem64;
  logic [63:0]     ext64;
  logic [2:0]      off;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic [31:0]     word_v;

  assign commit = valid_in && (state == IDLE);

  // Lane extraction: on a 32-bit datapath only offset[1:0] addresses the read word.
  always_comb begin
    mem64  = 64'(memory_read_value);
    off    = IS64 ? alu_output[2:0] : {1'b0, alu_output[1:0]};
    byte_v = 8'(mem64 >> {off, 3'b000});
    half_v = 16'(mem64 >> {off[2:1], 4'b0000});
    word_v = 32'(mem64 >> {off[2], 5'b00000});
    case (load_type)
      3'b000:  ext64 = {{56{byte_v[7]}}, byte_v};
      3'b001:  ext64 = {{48{half_v[15]}}, half_v};
      3'b011:  ext64 = IS64 ? mem64 : {{32{word_v[31]}}, word_v};
      3'b100:  ext64 = {56'b0, byte_v};
      3'b101:  ext64 = {48'b0, half_v};
      3'b110:  ext64 = IS64 ? {32'b0, word_v} : {{32{word_v[31]}}, word_v};
      default: ext64 = {{32{word_v[31]}}, word_v};
    endcase
    load_value = XLEN'(ext64);
  end

  always_comb begin
    if (is_load)
      rd_value = load_value;
    else if (is_jal || is_jalr)
      rd_value = instr_pc + XLEN'(4);
    else
      rd_value = alu_output;
  end

  assign reg_we = commit && !is_store && !is_branch && (rd != '0);

  assign take   = is_jal || is_jalr || (is_branch && |(branch_type & compare));
  assign target = is_jalr ? {alu_output[XLEN-1:1], 1'b0} : instr_pc + imm;

  assign redirect        = commit && take;
  assign misaligned_trap = redirect && (target[1:0] != 2'b00);
  assign next_target     = misaligned_trap ? TRAP_VEC : target;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      instruction_addr <= RESET_PC;
    else if (redirect)
      instruction_addr <= next_target;
    else if (!stall)
      instruction_addr <= instruction_addr + XLEN'(4);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      flush <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      flush <= flush_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (redirect) begin
          state_nx = SQUASH;
          cnt_nx   = CW'(FLUSH_CYCLES);
        end
      end
      SQUASH: begin
        cnt_nx = cnt - CW'(1);
        if (cnt == CW'(1))
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    flush_nx = (state_nx == SQUASH);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      retired_count <= '0;
    else if (commit)
      retired_count <= retired_count + 64'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (reg_we) begin
      regs[rd] <= rd_value;
    end
  end

  always_comb begin
    rs1_read = (rs1 == '0) ? '0 : regs[rs1];
    rs2_read = (rs2 == '0) ? '0 : regs[rs2];
`ifdef STAGE5_BYPASS_EN
    if (reg_we && (rs1 == rd))
      rs1_read = rd_value;
    if (reg_we && (rs2 == rd))
      rs2_read = rd_value;
`endif
  end

endmodule

// File: tb/tb_stage5_commit_unit.sv
// Directed bench for stage5_commit_unit: vector table plus redirect/squash/reset sequences.
module tb_stage5_commit_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid_in, stall;
  logic        is_load, is_store, is_branch, is_jal, is_jalr;
  logic [3:0]  branch_type, compare;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] instr_pc, alu_output, memory_read_value, imm;
  logic [2:0]  load_type;
  logic [31:0] instruction_addr, rs1_read, rs2_read;
  logic        redirect, flush, misaligned_trap;
  logic [63:0] retired_count;

  stage5_commit_unit dut (
    .clock(clock), .reset(reset), .valid_in(valid_in), .stall(stall),
    .is_load(is_load), .is_store(is_store), .is_branch(is_branch),
    .is_jal(is_jal), .is_jalr(is_jalr), .branch_type(branch_type),
    .compare(compare), .rs1(rs1), .rs2(rs2), .rd(rd), .instr_pc(instr_pc),
    .alu_output(alu_output), .memory_read_value(memory_read_value),
    .imm(imm), .load_type(load_type), .instruction_addr(instruction_addr),
    .rs1_read(rs1_read), .rs2_read(rs2_read), .redirect(redirect),
    .flush(flush), .misaligned_trap(misaligned_trap),
    .retired_count(retired_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        ld, st, br;
    logic [3:0]  bt, cmp;
    logic [4:0]  rs, rd;
    logic [31:0] alu, mem;
    logic [2:0]  lt;
    logic        stall;
    logic [31:0] exp_now, exp_after;
  } vec_t;

  vec_t        vt[13];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_pc;
  logic [63:0] exp_ret;
  logic [31:0] byp;
  int          n;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clr();
    valid_in = 0; stall = 0; is_load = 0; is_store = 0; is_branch = 0;
    is_jal = 0; is_jalr = 0; branch_type = 0; compare = 0; rs2 = 0; rd = 0;
    instr_pc = 0; alu_output = 0; memory_read_value = 0; imm = 0; load_type = 0;
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  task automatic wait_squash(input string nm);
    n = 0;
    while (flush && n < 20) begin
      n++;
      step();
    end
    check(nm, 64'(n), 64'd4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef STAGE5_BYPASS_EN
    byp = 32'h0000DEAD;
`else
    byp = 32'h0;
`endif
    //          ld    st    br    bt     cmp    rs     rd     alu            mem            lt      stall now            after
    vt[0]  = '{1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 5'd5,  5'd5,  32'h1,        32'h11228380, 3'b000, 1'b0, 32'h0,        32'hFFFFFF83};
    vt[1]  = '{1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 5'd5,  5'd5,  32'h1,        32'h11228380, 3'b100, 1'b0, 32'hFFFFFF83, 32'h00000083};
    vt[2]  = '{1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 5'd6,  5'd6,  32'h2,        32'h11228380, 3'b001, 1'b0, 32'h0,        32'h00001122};
    vt[3]  = '{1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 5'd8,  5'd8,  32'h0,        32'h11228380, 3'b001, 1'b0, 32'h0,        32'hFFFF8380};
    vt[4]  = '{1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 5'd9,  5'd9,  32'h0,        32'h11228380, 3'b010, 1'b0, 32'h0,        32'h11228380};
    vt[5]  = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 5'd10, 5'd10, 32'h12345678, 32'h0,        3'b000, 1'b0, 32'h0,        32'h12345678};
    vt[6]  = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 5'd11, 5'd11, 32'h55,       32'h0,        3'b000, 1'b0, 32'h0,        32'h0};
    vt[7]  = '{1'b0, 1'b0, 1'b1, 4'h2, 4'h1, 5'd12, 5'd12, 32'h77,       32'h0,        3'b000, 1'b0, 32'h0,        32'h0};
    vt[8]  = '{1'b0, 1'b0, 1'b1, 4'h2, 4'h1, 5'd12, 5'd12, 32'h77,       32'h0,        3'b000, 1'b1, 32'h0,        32'h0};
    vt[9]  = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 5'd0,  5'd0,  32'hFFFF,     32'h0,        3'b000, 1'b0, 32'h0,        32'h0};
    vt[10] = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 5'd7,  5'd7,  32'hDEAD,     32'h0,        3'b000, 1'b0, byp,          32'h0000DEAD};
    vt[11] = '{1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 5'd5,  5'd5,  32'h3,        32'h11228380, 3'b100, 1'b0, 32'h00000083, 32'h00000011};
    vt[12] = '{1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 5'd14, 5'd14, 32'h0,        32'h11228380, 3'b101, 1'b0, 32'h0,        32'h00008380};

    clr();
    rs1 = 5'd5;
    reset = 1'b0;
    #3;
    check("rst_pc", 64'(instruction_addr), 64'h0);
    check("rst_flush", 64'(flush), 64'h0);
    check("rst_retired", retired_count, 64'h0);
    check("rst_reg", 64'(rs1_read), 64'h0);
    @(negedge clock);
    reset = 1'b1;
    exp_pc = 32'h0;
    exp_ret = 64'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_pc += 32'd4;
      check("boot_pc", 64'(instruction_addr), 64'(exp_pc));
      check("boot_flush", 64'(flush), 64'h0);
    end
    check("boot_retired", retired_count, 64'h0);

    for (int i = 0; i < 13; i++) begin
      clr();
      valid_in = 1'b1;
      is_load = vt[i].ld; is_store = vt[i].st; is_branch = vt[i].br;
      branch_type = vt[i].bt; compare = vt[i].cmp; rs1 = vt[i].rs;
      rd = vt[i].rd; alu_output = vt[i].alu; memory_read_value = vt[i].mem;
      load_type = vt[i].lt; stall = vt[i].stall; instr_pc = 32'h400;
      #1;
      check($sformatf("v%0d_redirect", i), 64'(redirect), 64'h0);
      check($sformatf("v%0d_rs1_now", i), 64'(rs1_read), 64'(vt[i].exp_now));
      step();
      exp_ret += 64'd1;
      if (!vt[i].stall) exp_pc += 32'd4;
      clr();
      rs1 = vt[i].rd;
      #1;
      check($sformatf("v%0d_rd_after", i), 64'(rs1_read), 64'(vt[i].exp_after));
      check($sformatf("v%0d_pc", i), 64'(instruction_addr), 64'(exp_pc));
      check($sformatf("v%0d_retired", i), retired_count, exp_ret);
    end

    // jal: redirect, 4 squash cycles ignoring valid slots, then commits resume
    clr();
    valid_in = 1; is_jal = 1; instr_pc = 32'h40; imm = 32'h20; rd = 5'd1;
    #1;
    check("jal_redirect", 64'(redirect), 64'h1);
    check("jal_trap", 64'(misaligned_trap), 64'h0);
    step();
    exp_ret += 64'd1;
    clr();
    rs1 = 5'd1;
    #1;
    check("jal_pc", 64'(instruction_addr), 64'h60);
    check("jal_link", 64'(rs1_read), 64'h44);
    valid_in = 1; is_jal = 1; instr_pc = 32'h300; imm = 32'h4; rd = 5'd13;
    rs1 = 5'd13;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("sq%0d_flush", i), 64'(flush), 64'h1);
      check($sformatf("sq%0d_redirect", i), 64'(redirect), 64'h0);
      step();
    end
    check("sq_end_flush", 64'(flush), 64'h0);
    check("sq_resume_redirect", 64'(redirect), 64'h1);
    clr();
    #1;
    check("sq_reg13", 64'(rs1_read), 64'h0);
    check("sq_retired", retired_count, exp_ret);
    check("sq_pc", 64'(instruction_addr), 64'h70);

    // jalr to a misaligned target traps to TRAP_VEC
    valid_in = 1; is_jalr = 1; alu_output = 32'h103; instr_pc = 32'h80; rd = 5'd2;
    #1;
    check("jalr_redirect", 64'(redirect), 64'h1);
    check("jalr_trap", 64'(misaligned_trap), 64'h1);
    step();
    exp_ret += 64'd1;
    clr();
    rs1 = 5'd2;
    #1;
    check("jalr_pc", 64'(instruction_addr), 64'h100);
    check("jalr_link", 64'(rs1_read), 64'h84);
    wait_squash("jalr_flush_len");
    check("jalr_pc_after", 64'(instruction_addr), 64'h110);

    // taken beq with stall: redirect wins over the hold
    valid_in = 1; is_branch = 1; branch_type = 4'h1; compare = 4'h1;
    instr_pc = 32'h200; imm = 32'h10; stall = 1; rd = 5'd3;
    #1;
    check("br_stall_redirect", 64'(redirect), 64'h1);
    check("br_stall_trap", 64'(misaligned_trap), 64'h0);
    step();
    exp_ret += 64'd1;
    clr();
    rs1 = 5'd3;
    #1;
    check("br_stall_pc", 64'(instruction_addr), 64'h210);
    check("br_no_write", 64'(rs1_read), 64'h0);
    wait_squash("br_flush_len");
    check("br_retired", retired_count, exp_ret);

    // reset in the middle of a squash aborts it at once
    valid_in = 1; is_jal = 1; instr_pc = 32'h40; imm = 32'h20; rd = 5'd3;
    step();
    clr();
    step();
    check("mid_flush", 64'(flush), 64'h1);
    reset = 1'b0;
    rs1 = 5'd5;
    #1;
    check("mid_rst_flush", 64'(flush), 64'h0);
    check("mid_rst_pc", 64'(instruction_addr), 64'h0);
    check("mid_rst_retired", retired_count, 64'h0);
    check("mid_rst_reg", 64'(rs1_read), 64'h0);
    reset = 1'b1;
    step();
    check("post_rst_pc", 64'(instruction_addr), 64'h4);
    check("post_rst_flush", 64'(flush), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stage5_commit_unit.md
# stage5_commit_unit

Parametrised successor to the stage-5 writeback/branch-resolution logic of the 7-stage RISC-V pipeline. It selects and formats the writeback value, including load byte-lane extraction and extension. It owns the architectural register file and the fetch program counter. It resolves jumps and branches into a redirect. It runs a squash FSM that flushes the younger in-flight instructions for a configurable number of cycles, and it keeps a retired-instruction counter.

## Interface
- XLEN, 32: datapath width; legal values are 32 and 64.
- NREGS, 32: number of architectural registers; x0 is hardwired to zero.
- FLUSH_CYCLES, 4: number of younger pipeline slots squashed after a redirect; must be 1 or more.
- RESET_PC, 0: value of instruction_addr after reset.
- TRAP_VEC, 'h100: redirect target used when a jump/branch target is misaligned.

Ports:
- clock  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset.
- valid_in  in  1  stage-5 slot holds a real instruction.
- stall  in  1  hold the fetch PC.
- is_load, is_store, is_branch, is_jal, is_jalr  in  1 each  instruction class, one-hot or all zero.
- branch_type  in  4  one-hot {ge,lt,ne,eq} condition requested.
- compare  in  4  {ge,lt,ne,eq} comparison results from the ALU stage.
- rs1, rs2, rd  in  $clog2(NREGS)  register tags.
- instr_pc  in  XLEN  PC of the stage-5 instruction.
- alu_output, memory_read_value, imm  in  XLEN  operands.
- load_type  in  3  funct3: LB 000, LH 001, LW 010, LD 011, LBU 100, LHU 101, LWU 110.
- instruction_addr  out  XLEN  fetch PC.
- rs1_read, rs2_read  out  XLEN  combinational register-file reads.
- redirect  out  1  combinational; taken control transfer this cycle.
- flush  out  1  registered; squash younger stages.
- misaligned_trap  out  1  combinational; target[1:0] is non-zero on a redirect.
- retired_count  out  64  committed-instruction counter.

## Operation
- A slot commits when valid_in is 1 and the FSM is in IDLE. A slot presented during SQUASH is ignored: no write, no redirect, no count.
- Load formatting uses alu_output[2:0] as the byte offset:
  - byte: lane offset.
  - half: lane offset[2:1].
  - word: lane offset[2].
  - Sign-extend or zero-extend to XLEN according to load_type.
  - LD, and LWU zero-extension, are legal only when XLEN is 64; otherwise the value is treated as LW.
- rd_value is selected in priority order:
  - load: the formatted read value;
  - jal or jalr: instr_pc + 4;
  - otherwise: alu_output.
- Register write happens when the slot commits, it is not a store or branch, and rd is non-zero.
- take condition: is_jal, or is_jalr, or (is_branch and the OR over i of branch_type[i] & compare[i]).
- target:
  - jalr: alu_output with bit 0 cleared.
  - otherwise: instr_pc + imm, modulo 2^XLEN.
- redirect = commit & take. misaligned_trap = redirect & (target[1:0] != 0). When misaligned_trap is 1, the effective target is TRAP_VEC.
- PC update priority: redirect, then stall (hold), then instruction_addr + 4.
- Squash FSM:
  - IDLE: on redirect, load the counter with FLUSH_CYCLES and go to SQUASH.
  - SQUASH: flush = 1; decrement the counter each cycle; return to IDLE after the cycle in which the counter reaches 1.
  - stall does not pause the counter.
- retired_count increments by 1 on every commit, including stores, branches and redirecting instructions. It wraps at 2^64.
- Reads of x0 return 0. Reads of other registers return the stored value.

## Timing
- Reset is asynchronous, active-low. While reset is low:
  - instruction_addr = RESET_PC;
  - flush = 0 and the FSM is in IDLE;
  - retired_count = 0;
  - all registers = 0.
- Reset asserted mid-SQUASH aborts the squash immediately.
- Register write, PC update, FSM and counter all change on the rising clock edge.
- rs1_read, rs2_read, redirect and misaligned_trap are combinational, with zero latency.
- Redirect at cycle N:
  - instruction_addr = target from cycle N+1;
  - flush = 1 for cycles N+1 through N+FLUSH_CYCLES;
  - commits resume at cycle N+FLUSH_CYCLES+1.
- Redirect together with stall: the redirect wins.

## Configuration
- STAGE5_BYPASS_EN defined: a read whose tag equals the rd being written in the same cycle returns rd_value (write-through), except for x0.
- STAGE5_BYPASS_EN undefined: such a read returns the old register value; the new value is visible from the next cycle.

## Test plan
- Reset, then release with stall=0: instruction_addr goes 0, 4, 8, 12; flush=0; retired_count=0.
- LB with memory_read_value=0x11228380, alu_output[1:0]=1, rd=5 -> x5=0xFFFFFF83. LBU under the same conditions -> x5=0x00000083.
- jal at instr_pc=0x40, imm=0x20, rd=1 -> x1=0x44; next instruction_addr=0x60; flush high for 4 cycles; valid slots presented during those 4 cycles leave the registers and retired_count unchanged.
- jalr with alu_output=0x103 -> target 0x102, which is misaligned -> misaligned_trap=1 and next instruction_addr=TRAP_VEC.
- bne with compare eq=1 and ne=0 -> no redirect and PC advances by 4. The same instruction with stall=1 holds the PC. A taken branch with stall=1 still redirects.
- Write x7=0xDEAD while reading rs1=7 in the same cycle: with STAGE5_BYPASS_EN, rs1_read=0xDEAD; without it, rs1_read returns the old value. Writes to x0 always read back 0.
